// File: rtl/uart_cmd_decoder.sv
// UART RX byte-stream command decoder: single-char pulses plus "T"+HHMMSS set-time sequence.
// Optional macro CMD_CASE_INSENSITIVE_EN: lowercase command letters decode as uppercase.
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int SEC_MAX        = 60,
  parameter int MIN_MAX        = 60,
  parameter int HOUR_MAX       = 24,
  localparam int SW = $clog2(SEC_MAX),
  localparam int MW = $clog2(MIN_MAX),
  localparam int HW = $clog2(HOUR_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          run_stop,
  output logic          clear,
  output logic          hour_add,
  output logic          min_add,
  output logic          sec_add,
  output logic          set_time,
  output logic [HW-1:0] set_hour,
  output logic [MW-1:0] set_min,
  output logic [SW-1:0] set_sec,
  output logic          busy,
  output logic          err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, DIGIT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    idx;
  logic [3:0]    dig [0:4];
  logic [TW-1:0] cnt;

  logic [7:0] cmd;
  logic       is_digit, timeout_hit, time_ok;
  logic [6:0] hh, mm, ss;
  logic       run_stop_nxt, clear_nxt, hour_add_nxt, min_add_nxt, sec_add_nxt;
  logic       set_time_nxt, err_nxt;

`ifdef CMD_CASE_INSENSITIVE_EN
  assign cmd = (rx_data >= "a" && rx_data <= "z") ? rx_data - 8'd32 : rx_data;
`else
  assign cmd = rx_data;
`endif

  assign is_digit    = (rx_data >= "0") && (rx_data <= "9");
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == DIGIT) && !rx_valid && (cnt == TO_LAST);

  // The sixth digit comes straight from rx_data so the check happens on the same edge it arrives.
  assign hh      = 7'(dig[0]) * 7'd10 + 7'(dig[1]);
  assign mm      = 7'(dig[2]) * 7'd10 + 7'(dig[3]);
  assign ss      = 7'(dig[4]) * 7'd10 + 7'(rx_data[3:0]);
  assign time_ok = (32'(hh) < HOUR_MAX) && (32'(mm) < MIN_MAX) && (32'(ss) < SEC_MAX);

  assign busy = (state == DIGIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_valid && cmd == "T") state_nxt = DIGIT;
      DIGIT: begin
        if (rx_valid) begin
          if (!is_digit || idx == 3'd5) state_nxt = IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run_stop_nxt = 1'b0;
    clear_nxt    = 1'b0;
    hour_add_nxt = 1'b0;
    min_add_nxt  = 1'b0;
    sec_add_nxt  = 1'b0;
    set_time_nxt = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (cmd)
            "R":                  run_stop_nxt = 1'b1;
            "C":                  clear_nxt    = 1'b1;
            "H":                  hour_add_nxt = 1'b1;
            "M":                  min_add_nxt  = 1'b1;
            "S":                  sec_add_nxt  = 1'b1;
            "T", 8'h0D, 8'h0A, 8'h20: ;
            default:              err_nxt      = 1'b1;
          endcase
        end
      end
      DIGIT: begin
        if (rx_valid) begin
          if (!is_digit)          err_nxt      = 1'b1;
          else if (idx == 3'd5) begin
            set_time_nxt = time_ok;
            err_nxt      = !time_ok;
          end
        end else if (timeout_hit) begin
          err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      cnt      <= '0;
      for (int i = 0; i < 5; i++) dig[i] <= '0;
      run_stop <= 1'b0;
      clear    <= 1'b0;
      hour_add <= 1'b0;
      min_add  <= 1'b0;
      sec_add  <= 1'b0;
      set_time <= 1'b0;
      err      <= 1'b0;
      set_hour <= '0;
      set_min  <= '0;
      set_sec  <= '0;
    end else begin
      run_stop <= run_stop_nxt;
      clear    <= clear_nxt;
      hour_add <= hour_add_nxt;
      min_add  <= min_add_nxt;
      sec_add  <= sec_add_nxt;
      set_time <= set_time_nxt;
      err      <= err_nxt;
      cnt      <= (state != DIGIT || rx_valid) ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        idx <= '0;
      end else if (rx_valid && is_digit && idx != 3'd5) begin
        dig[idx] <= rx_data[3:0];
        idx      <= idx + 3'd1;
      end
      if (set_time_nxt) begin
        set_hour <= HW'(hh);
        set_min  <= MW'(mm);
        set_sec  <= SW'(ss);
      end
    end
  end

endmodule
